// File: rtl/rot_pattern_seq.sv
// Rotating-pattern sequencer: holds an 8-bit pattern, steps a 3-bit shift count
// every PERIOD cycles and produces the registered rotated pattern.
module rot_pattern_seq #(
  parameter int unsigned PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] pat_in,
  input  logic       dir_in,
  input  logic       bounce_in,
  input  logic       stop,
  output logic [7:0] a_out,
  output logic [2:0] sc_out,
  output logic       dir_out,
  output logic [7:0] rot_out,
  output logic       step_pulse,
  output logic       wrap,
  output logic       o_dbg_state
);

  localparam int unsigned   TW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [7:0]    r_a;
  logic [7:0]    w_a_nxt;
  logic [2:0]    r_sc;
  logic [2:0]    w_sc_nxt;
  logic          r_dir;
  logic          w_dir_nxt;
  logic          r_bounce;
  logic          w_bounce_nxt;
  logic [7:0]    r_rot;
  logic [7:0]    w_rot_nxt;
  logic          r_step;
  logic          w_step_nxt;
  logic          r_wrap;
  logic          w_wrap_nxt;

  // Pure 8-bit rotate: right = 1 rotates toward bit 0, count 0 is identity.
  function automatic logic [7:0] rotate8(input logic [7:0] a, input logic [2:0] n,
                                         input logic right);
    logic [15:0] dbl;
    dbl = {a, a};
    if (right) dbl = dbl >> n;
    else       dbl = dbl << n;
    return right ? dbl[7:0] : dbl[15:8];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_a      <= 8'd0;
      r_sc     <= 3'd0;
      r_dir    <= 1'b0;
      r_bounce <= 1'b0;
      r_rot    <= 8'd0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_a      <= w_a_nxt;
      r_sc     <= w_sc_nxt;
      r_dir    <= w_dir_nxt;
      r_bounce <= w_bounce_nxt;
      r_rot    <= w_rot_nxt;
      r_step   <= w_step_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // Load beats stop beats stepping; a load edge never steps.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_a_nxt      = r_a;
    w_sc_nxt     = r_sc;
    w_dir_nxt    = r_dir;
    w_bounce_nxt = r_bounce;
    w_step_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_rot_nxt    = rotate8(r_a, r_sc, r_dir);

    if (load) begin
      w_state_nxt  = S_RUN;
      w_timer_nxt  = '0;
      w_a_nxt      = pat_in;
      w_sc_nxt     = 3'd0;
      w_dir_nxt    = dir_in;
      w_bounce_nxt = bounce_in;
    end else if (stop) begin
      w_state_nxt = S_IDLE;
    end else if (r_state == S_RUN) begin
      if (r_timer == TMAX) begin
        w_timer_nxt = '0;
        w_sc_nxt    = r_sc + 3'd1;
        w_step_nxt  = 1'b1;
        if (r_sc == 3'd7) begin
          w_wrap_nxt = 1'b1;
          if (r_bounce) w_dir_nxt = ~r_dir;
        end
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end
  end

  assign a_out       = r_a;
  assign sc_out      = r_sc;
  assign dir_out     = r_dir;
  assign rot_out     = r_rot;
  assign step_pulse  = r_step;
  assign wrap        = r_wrap;
  assign o_dbg_state = r_state;

  a_wrap_has_step: assert property (@(posedge clk) disable iff (reset) wrap |-> step_pulse);

endmodule
